// File: rtl/register_file_sb.sv
// Parametrised 1W/2R register file with optional zero register, same-cycle
// write bypass, and a per-register busy scoreboard for in-flight producers.
module register_file_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WE3,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] A3,
    input  logic [XLEN-1:0]   WD3,
    input  logic              SB_SET,
    input  logic [ADDR_W-1:0] SB_A,
    output logic [XLEN-1:0]   RD1,
    output logic [XLEN-1:0]   RD2,
    output logic              BUSY1,
    output logic              BUSY2,
    output logic [ADDR_W:0]   BUSY_CNT
);

    logic [XLEN-1:0] rf_q [NREG];
    logic [XLEN-1:0] rf_d [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic [ADDR_W:0] cnt_q, cnt_d;
    logic            wr_ok, set_ok;

    // An address is usable only if it maps to a real, writable register.
    function automatic logic legal(input logic [ADDR_W-1:0] a);
        return (int'(a) < NREG) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr_ok  = WE3 && legal(A3);
    assign set_ok = SB_SET && legal(SB_A);

    always_comb begin
        rf_d   = rf_q;
        busy_d = busy_q;
        for (int i = 0; i < NREG; i++) begin
            if (wr_ok && (A3 == ADDR_W'(i))) begin
                rf_d[i]   = WD3;
                busy_d[i] = 1'b0;
            end
            // Applied after the clear so a new producer supersedes the writeback.
            if (set_ok && (SB_A == ADDR_W'(i)))
                busy_d[i] = 1'b1;
        end
        cnt_d = '0;
        for (int i = 0; i < NREG; i++)
            cnt_d = cnt_d + (ADDR_W+1)'(busy_d[i]);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rf_q   <= '{default: '0};
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            rf_q   <= rf_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        RD1   = '0;
        RD2   = '0;
        BUSY1 = 1'b0;
        BUSY2 = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (A1 == ADDR_W'(i)) begin
                RD1   = rf_q[i];
                BUSY1 = busy_q[i];
            end
            if (A2 == ADDR_W'(i)) begin
                RD2   = rf_q[i];
                BUSY2 = busy_q[i];
            end
        end
        if ((BYPASS != 0) && wr_ok && (A3 == A1)) begin
            RD1 = WD3;
            if (!(set_ok && (SB_A == A1)))
                BUSY1 = 1'b0;
        end
        if ((BYPASS != 0) && wr_ok && (A3 == A2)) begin
            RD2 = WD3;
            if (!(set_ok && (SB_A == A2)))
                BUSY2 = 1'b0;
        end
        if (!legal(A1)) begin
            RD1   = '0;
            BUSY1 = 1'b0;
        end
        if (!legal(A2)) begin
            RD2   = '0;
            BUSY2 = 1'b0;
        end
    end

    assign BUSY_CNT = cnt_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb: default build plus a 16-entry,
// no-zero-register, no-bypass build sharing the same stimulus.
module tb_register_file_sb;

    logic        CLK = 1'b0;
    logic        RST;
    logic        WE3, SB_SET;
    logic [4:0]  A1, A2, A3, SB_A;
    logic [31:0] WD3;

    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic        b1_a, b2_a, b1_b, b2_b;
    logic [5:0]  cnt_a, cnt_b;

    int n_chk = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    register_file_sb u_dut (
        .CLK(CLK), .RST(RST), .WE3(WE3), .A1(A1), .A2(A2), .A3(A3), .WD3(WD3),
        .SB_SET(SB_SET), .SB_A(SB_A), .RD1(rd1_a), .RD2(rd2_a),
        .BUSY1(b1_a), .BUSY2(b2_a), .BUSY_CNT(cnt_a)
    );

    register_file_sb #(.NREG(16), .ZERO_REG(0), .BYPASS(0)) u_d16 (
        .CLK(CLK), .RST(RST), .WE3(WE3), .A1(A1), .A2(A2), .A3(A3), .WD3(WD3),
        .SB_SET(SB_SET), .SB_A(SB_A), .RD1(rd1_b), .RD2(rd2_b),
        .BUSY1(b1_b), .BUSY2(b2_b), .BUSY_CNT(cnt_b)
    );

    typedef struct {
        logic        we;
        logic [4:0]  a1, a2, a3;
        logic [31:0] wd;
        logic        sbset;
        logic [4:0]  sba;
        logic [31:0] e_rd1, e_rd2;
        logic        e_b1, e_b2;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t vec [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] a3, input logic [31:0] wd,
                         input logic sbset, input logic [4:0] sba);
        WE3 = we; A1 = a1; A2 = a2; A3 = a3; WD3 = wd; SB_SET = sbset; SB_A = sba;
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        //            we  a1 a2 a3  wd            set sba  rd1           rd2           b1 b2 cnt
        vec[0]  = '{1'b1, 0, 0, 0, 32'h0ABCDEF0, 1'b1, 0, 32'h0,        32'h0,        0, 0, 0};
        vec[1]  = '{1'b0, 0, 0, 0, 32'h0,        1'b0, 0, 32'h0,        32'h0,        0, 0, 0};
        vec[2]  = '{1'b1, 1, 2, 1, 32'h0ABCDEF0, 1'b0, 0, 32'h0ABCDEF0, 32'h0,        0, 0, 0};
        vec[3]  = '{1'b1, 1, 4, 4, 32'hFFFFFFFF, 1'b0, 0, 32'h0ABCDEF0, 32'hFFFFFFFF, 0, 0, 0};
        vec[4]  = '{1'b0, 1, 4, 0, 32'h0,        1'b0, 0, 32'h0ABCDEF0, 32'hFFFFFFFF, 0, 0, 0};
        vec[5]  = '{1'b0, 7, 7, 0, 32'h0,        1'b1, 7, 32'h0,        32'h0,        0, 0, 0};
        vec[6]  = '{1'b0, 7, 7, 0, 32'h0,        1'b0, 0, 32'h0,        32'h0,        1, 1, 1};
        vec[7]  = '{1'b1, 7, 9, 7, 32'h12345678, 1'b0, 0, 32'h12345678, 32'h0,        0, 0, 1};
        vec[8]  = '{1'b0, 7, 9, 0, 32'h0,        1'b1, 9, 32'h12345678, 32'h0,        0, 0, 0};
        vec[9]  = '{1'b1, 9, 9, 9, 32'hCAFEF00D, 1'b1, 9, 32'hCAFEF00D, 32'hCAFEF00D, 1, 1, 1};
        vec[10] = '{1'b0, 9, 9, 0, 32'h0,        1'b0, 0, 32'hCAFEF00D, 32'hCAFEF00D, 1, 1, 1};
        vec[11] = '{1'b1, 9, 3, 9, 32'h0,        1'b1, 3, 32'h0,        32'h0,        0, 0, 1};
        vec[12] = '{1'b0, 3, 9, 0, 32'h0,        1'b0, 0, 32'h0,        32'h0,        1, 0, 1};
        vec[13] = '{1'b0, 31, 1, 0, 32'h0,       1'b0, 0, 32'h0,        32'h0ABCDEF0, 0, 0, 1};

        RST = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("reset_rd1", rd1_a, 32'h0);
        chk("reset_busy1", 32'(b1_a), 32'h0);
        chk("reset_cnt", 32'(cnt_a), 32'h0);
        chk("reset_cnt16", 32'(cnt_b), 32'h0);
        step();
        RST = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(vec[i].we, vec[i].a1, vec[i].a2, vec[i].a3, vec[i].wd, vec[i].sbset, vec[i].sba);
            #3;
            chk($sformatf("v%0d_rd1", i), rd1_a, vec[i].e_rd1);
            chk($sformatf("v%0d_rd2", i), rd2_a, vec[i].e_rd2);
            chk($sformatf("v%0d_busy1", i), 32'(b1_a), 32'(vec[i].e_b1));
            chk($sformatf("v%0d_busy2", i), 32'(b2_a), 32'(vec[i].e_b2));
            chk($sformatf("v%0d_cnt", i), 32'(cnt_a), 32'(vec[i].e_cnt));
            step();
        end

        // Asynchronous reset mid-cycle wipes data, busy bits and the count.
        drive(1, 5, 6, 5, 32'hDEADBEEF, 1, 6);
        step();
        drive(0, 5, 6, 0, 0, 0, 0);
        #2;
        chk("pre_rst_rd1", rd1_a, 32'hDEADBEEF);
        chk("pre_rst_busy2", 32'(b2_a), 32'h1);
        chk("pre_rst_cnt", 32'(cnt_a), 32'h2);
        RST = 1'b1;
        #1;
        chk("async_rst_rd1", rd1_a, 32'h0);
        chk("async_rst_busy2", 32'(b2_a), 32'h0);
        chk("async_rst_cnt", 32'(cnt_a), 32'h0);
        drive(1, 8, 5, 8, 32'h11111111, 1, 8);
        step();
        drive(0, 8, 5, 0, 0, 0, 0);
        RST = 1'b0;
        step();
        chk("rst_drop_write_r8", rd1_a, 32'h0);
        chk("rst_r5_stays_0", rd2_a, 32'h0);
        chk("rst_drop_set_cnt", 32'(cnt_a), 32'h0);

        // No-bypass build: write appears only after the edge.
        drive(1, 1, 2, 1, 32'h0ABCDEF0, 0, 0);
        #2;
        chk("nobyp_pre_rd1", rd1_b, 32'h0);
        step();
        drive(0, 1, 2, 0, 0, 0, 0);
        #2;
        chk("nobyp_post_rd1", rd1_b, 32'h0ABCDEF0);

        // Register 0 is ordinary when the zero register is disabled.
        drive(1, 0, 0, 0, 32'h00000055, 0, 0);
        #2;
        chk("r0_pre", rd1_b, 32'h0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("r0_written", rd1_b, 32'h00000055);
        chk("r0_zero_dflt", rd1_a, 32'h0);

        // Out-of-range address on the 16-entry build must not alias onto r4.
        drive(1, 20, 4, 20, 32'hFFFFFFFF, 1, 20);
        #2;
        chk("oor_pre_rd1", rd1_b, 32'h0);
        chk("oor_pre_busy1", 32'(b1_b), 32'h0);
        step();
        drive(0, 20, 4, 0, 0, 0, 0);
        #2;
        chk("oor_post_rd1", rd1_b, 32'h0);
        chk("oor_post_busy1", 32'(b1_b), 32'h0);
        chk("oor_r4_intact", rd2_b, 32'h0);
        chk("oor_cnt", 32'(cnt_b), 32'h0);

        for (int i = 0; i < 16; i++) begin
            drive(0, 15, 0, 0, 0, 1, 5'(i));
            step();
        end
        drive(0, 15, 0, 0, 0, 0, 0);
        #2;
        chk("fill_cnt16", 32'(cnt_b), 32'd16);
        chk("fill_busy15", 32'(b1_b), 32'h1);
        // Default build: r0 never busy, plus r20 set during the out-of-range step.
        chk("fill_cnt_zero_reg", 32'(cnt_a), 32'd16);

        // Without bypass, a releasing write clears busy only after the edge.
        drive(1, 15, 0, 15, 32'h0000BEEF, 0, 0);
        #2;
        chk("nobyp_busy_pre", 32'(b1_b), 32'h1);
        step();
        drive(0, 15, 0, 0, 0, 0, 0);
        #2;
        chk("nobyp_busy_post", 32'(b1_b), 32'h0);
        chk("nobyp_cnt_post", 32'(cnt_b), 32'd15);
        chk("nobyp_rd_post", rd1_b, 32'h0000BEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
